// File: rtl/ofifo_pkg.sv
// Shared widths for the MAC array output path. Keeping the column count, psum width
// and output FIFO depth here keeps the array and ofifo slices consistent.
package ofifo_pkg;

  localparam int array_col   = 8;
  localparam int psum_bw     = 16;
  localparam int ofifo_depth = 64;

  // One extra pointer bit separates full (same slot, other lap) from empty.
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_col.sv
// Single-column FIFO: storage plus read/write pointers. The head entry is presented
// combinationally on out; the parent registers it and gates rd with its global valid.
module fifo_col
  import ofifo_pkg::*;
#(
  parameter int bw    = psum_bw,
  parameter int depth = ofifo_depth
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [bw-1:0] in,
  input  logic          wr,
  input  logic          rd,
  output logic [bw-1:0] out,
  output logic          o_empty,
  output logic          o_full
);

  localparam int aw = $clog2(depth);
  localparam int pw = ptr_bits(depth);

  logic [bw-1:0] mem [depth];
  logic [pw-1:0] wptr;
  logic [pw-1:0] rptr;
  logic          wr_ok;

  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);

  // A read in the same edge frees the slot, so a full column still takes the write.
  assign wr_ok = wr && (!o_full || rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd)    rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[aw-1:0]] <= in;
  end

  assign out = mem[rptr[aw-1:0]];

endmodule

// File: rtl/ofifo.sv
// Output FIFO bank below the MAC array: one FIFO per column written by that column's
// valid bit, read as one aligned row across all columns.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col   = array_col,
  parameter int bw    = psum_bw,
  parameter int depth = ofifo_depth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col*bw-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_overflow
);

  // Handshake: a row transfers on a rising edge where rd && o_valid; upstream must
  // hold wr low while o_ready is low, a write into a full column only flags o_overflow.

  logic [col-1:0]    col_empty;
  logic [col-1:0]    col_full;
  logic [col*bw-1:0] head;
  logic              rd_acc;

  assign rd_acc = rd && o_valid;

  for (genvar i = 0; i < col; i++) begin : g_col
    fifo_col #(
      .bw    (bw),
      .depth (depth)
    ) u_col (
      .clk     (clk),
      .reset   (reset),
      .in      (in[bw*i +: bw]),
      .wr      (wr[i]),
      .rd      (rd_acc),
      .out     (head[bw*i +: bw]),
      .o_empty (col_empty[i]),
      .o_full  (col_full[i])
    );
  end

  assign o_valid = &(~col_empty);
  assign o_full  = |col_full;
  assign o_ready = ~o_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (rd_acc) out <= head;
      if (|(wr & col_full & ~{col{rd_acc}})) o_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/ofifo.md
# ofifo

Output FIFO bank that sits directly downstream of the MAC array and captures its south-edge partial sums. Each column has an independent FIFO written by that column's `valid` bit, because results emerge column-skewed. Reads pop all columns at once, so the consumer (SFU / output SRAM writer) receives one aligned row of `col` psums per read.

## Interface

**Parameters**
- `col`, 8: number of columns (independent FIFOs).
- `bw`, 16: data width per column; equals the array's `psum_bw`.
- `depth`, 64: entries per column FIFO; power of two, ≥ 2.

**Ports**
- `clk`, input, 1: single clock; everything is rising-edge.
- `reset`, input, 1: asynchronous, active-high.
- `in`, input, `col*bw`: column psums; column *i* is `in[bw*(i+1)-1:bw*i]` (connects to the array's `out_s`).
- `wr`, input, `col`: per-column write strobes (connects to the array's `valid`).
- `rd`, input, 1: pop one entry from every column.
- `out`, output, `col*bw`: registered aligned row, same column packing as `in`.
- `o_valid`, output, 1: every column is non-empty, so a read is possible.
- `o_full`, output, 1: at least one column is full.
- `o_ready`, output, 1: equals `~o_full`.
- `o_overflow`, output, 1: sticky; set by any write into a full column.

## Operation

- **Storage.** Per column: `depth` × `bw` storage, write pointer, read pointer.
  - Pointers are `$clog2(depth)+1` bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo `2*depth` naturally.
- **Column status.**
  - Empty: `wptr == rptr`.
  - Full: the low bits are equal and the MSBs differ.
- **Write.** When `wr[i]` is high and column *i* is not full:
  - store `in` slice *i* at the write pointer's low bits;
  - increment the write pointer.
- **Write into a full column.**
  - Data is dropped and the pointer does not move.
  - `o_overflow` is set and stays set until reset.
  - Other columns with `wr` high in the same cycle still write.
- **Read acceptance.** A read is accepted only when `rd && o_valid`.
  - On acceptance: every column's head entry goes to `out`, and every read pointer increments.
  - `rd` while `!o_valid` is ignored: no pointer moves and `out` holds.
- **Simultaneous read and write to one column.** Both happen, and the occupancy is unchanged.
  - This holds when the column is full: the read frees the slot in the same edge, so the write is accepted and there is no overflow.
  - This holds when the column is empty: `o_valid` is low, so the read is not accepted and the write proceeds.
- **Status outputs.** `o_valid`, `o_full` and `o_ready` are combinational from the pointers, with no dependence on `rd` or `wr`.
- **Reset values.**
  - All pointers are 0.
  - `out` = 0, `o_overflow` = 0.
  - Hence `o_valid` = 0, `o_full` = 0, `o_ready` = 1.
  - Storage contents are not reset.
- **Reset mid-operation.** All queued data is discarded immediately, asynchronously. The first write after reset deasserts lands in entry 0.

## Timing

- **Write to status.** A write at edge *t* updates the column's pointer at *t*. `o_valid` / `o_full` reflect it in the cycle after *t* (zero-cycle combinational status).
- **Read latency.** An accepted read sampled at edge *t* drives `out` from *t* (1-cycle registered latency). `out` holds until the next accepted read.
- **Back-to-back reads.** Allowed every cycle while `o_valid` stays high. Throughput is 1 row per cycle.
- **Fall-through.** Minimum write-to-readable latency is 1 cycle: the last column written at edge *t* can raise `o_valid` in cycle *t+1*.
- **Upstream contract.** The upstream controller must stall the array when `o_ready` is low. Overflow is an error-flag case only.

## Structure

- **Sub-module `fifo_col`.** One column: parameters `bw` and `depth`; ports `clk`, `reset`, `in`, `wr`, `rd`, `out`, `o_empty`, `o_full`.
  - It holds the pointers and storage.
  - `rd` is gated in the parent with the global `o_valid`.
- **`ofifo` itself.** A generate loop over `col` instances, plus:
  - the AND-reduce of non-empty flags (`o_valid`);
  - the OR-reduce of full flags (`o_full`);
  - the `out` register;
  - the sticky overflow flag.
- **Shared header.** The defaults for `col`, `bw` and `depth` belong in the project's shared defines header alongside the array's `psum_bw` / `col`, so widths stay consistent. No other typedefs are needed.

## Test plan

1. **Reset.** Assert `reset` asynchronously between edges → `o_valid`=0, `o_full`=0, `o_ready`=1, `o_overflow`=0, `out`=0 immediately.
2. **Skewed fill.** Write column *i* with value `16'h0100+i`, one column per cycle, columns 0..7 → `o_valid` rises only in the cycle after column 7's write. Then `rd`=1 → next cycle `out` = {`0107`,…,`0100`} and `o_valid`=0.
3. **Full / overflow.** Write 64 entries to every column → `o_full`=1, `o_ready`=0. A 65th write to column 3 → `o_overflow`=1, and a subsequent 64 reads return the original 64 rows in order.
4. **Simultaneous at full.** With all columns full, drive `rd`=1 and `wr`=`8'hFF` with data `16'hBEEF` → `o_full` stays 1, `o_overflow` stays 0, and after 63 more reads the 64th row read is all `BEEF`.
5. **Pointer wrap.** Stream 200 rows with continuous write/read → output sequence matches input exactly across pointer wrap, and `o_overflow`=0.
6. **Read when not valid.** `rd`=1 with column 5 empty and others non-empty → no pointer moves, `out` unchanged, occupancy of the other columns unchanged.
